// File: rtl/ps2_keyboard.sv
// ============================================================================
// Module   : ps2_keyboard
// Brief    : PS/2 scancode-set-2 keyboard receiver. Decodes make codes into
//            Apple-1 ASCII (upper case, bit 7 set) and exposes them through a
//            PIA-style KBD (addr 0) / KBDCR (addr 1) register pair.
// Options  : define PS2_TIMEOUT_EN to abort a stalled frame after TIMEOUT_US.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ps2_keyboard #(
  parameter int CLK_HZ     = 25000000,
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT_US = 200
) (
  input  logic       clk25,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_din,
  input  logic       cs,
  input  logic       enable,
  input  logic [1:0] address,
  output logic [7:0] dout,
  output logic       key_strobe,
  output logic       frame_err
);

  localparam int c_FW          = $clog2(FILTER_LEN + 1);
  localparam int c_TIMEOUT_CYC = int'((longint'(TIMEOUT_US) * longint'(CLK_HZ)) / longint'(1000000));
  localparam int c_TO_W        = $clog2(c_TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_BREAK     = 2'd1,
    ST_EXT       = 2'd2,
    ST_EXT_BREAK = 2'd3
  } state_t;

  logic [1:0]  r_sync1, r_sync2, w_filt;
  logic        r_clk_prev, w_fall;
  logic [3:0]  r_bit_cnt;
  logic [9:0]  r_shreg;
  logic [10:0] w_frame;
  logic        w_frame_ok;
  logic [7:0]  r_byte;
  logic        r_byte_vld, r_ferr;
  state_t      r_state;
  logic        r_shift, r_ready, r_overrun, r_strobe;
  logic [7:0]  r_key, r_dout;
  logic [8:0]  w_map;
  logic        w_is_shift, w_latch, w_rd, w_rd_kbd;

  // Scancode -> {valid, ASCII|0x80}; letters ignore shift, others use US layout.
  function automatic logic [8:0] f_map(input logic [7:0] code, input logic sh);
    logic [8:0] r;
    r = 9'h000;
    case (code)
      8'h1C: r = 9'h1C1; 8'h32: r = 9'h1C2; 8'h21: r = 9'h1C3; 8'h23: r = 9'h1C4;
      8'h24: r = 9'h1C5; 8'h2B: r = 9'h1C6; 8'h34: r = 9'h1C7; 8'h33: r = 9'h1C8;
      8'h43: r = 9'h1C9; 8'h3B: r = 9'h1CA; 8'h42: r = 9'h1CB; 8'h4B: r = 9'h1CC;
      8'h3A: r = 9'h1CD; 8'h31: r = 9'h1CE; 8'h44: r = 9'h1CF; 8'h4D: r = 9'h1D0;
      8'h15: r = 9'h1D1; 8'h2D: r = 9'h1D2; 8'h1B: r = 9'h1D3; 8'h2C: r = 9'h1D4;
      8'h3C: r = 9'h1D5; 8'h2A: r = 9'h1D6; 8'h1D: r = 9'h1D7; 8'h22: r = 9'h1D8;
      8'h35: r = 9'h1D9; 8'h1A: r = 9'h1DA;
      8'h45: r = {1'b1, sh ? 8'hA9 : 8'hB0};
      8'h16: r = {1'b1, sh ? 8'hA1 : 8'hB1};
      8'h1E: r = {1'b1, sh ? 8'hC0 : 8'hB2};
      8'h26: r = {1'b1, sh ? 8'hA3 : 8'hB3};
      8'h25: r = {1'b1, sh ? 8'hA4 : 8'hB4};
      8'h2E: r = {1'b1, sh ? 8'hA5 : 8'hB5};
      8'h36: r = {1'b1, sh ? 8'hDE : 8'hB6};
      8'h3D: r = {1'b1, sh ? 8'hA6 : 8'hB7};
      8'h3E: r = {1'b1, sh ? 8'hAA : 8'hB8};
      8'h46: r = {1'b1, sh ? 8'hA8 : 8'hB9};
      8'h41: r = {1'b1, sh ? 8'hBC : 8'hAC};
      8'h49: r = {1'b1, sh ? 8'hBE : 8'hAE};
      8'h4A: r = {1'b1, sh ? 8'hBF : 8'hAF};
      8'h4C: r = {1'b1, sh ? 8'hBA : 8'hBB};
      8'h52: r = {1'b1, sh ? 8'hA2 : 8'hA7};
      8'h4E: r = {1'b1, sh ? 8'hDF : 8'hAD};
      8'h55: r = {1'b1, sh ? 8'hAB : 8'hBD};
      8'h29: r = 9'h1A0;
      8'h5A: r = 9'h18D;
      8'h66: r = 9'h1DF;
      8'h76: r = 9'h19B;
      default: r = 9'h000;
    endcase
    return r;
  endfunction

  // Two-flop synchronisers; reset to idle-high so no edge is seen at release.
  always_ff @(posedge clk25 or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 2'b11;
      r_sync2 <= 2'b11;
    end else begin
      r_sync1 <= {ps2_din, ps2_clk};
      r_sync2 <= r_sync1;
    end
  end

  generate
    for (genvar g = 0; g < 2; g++) begin : g_filter
      logic            r_level;
      logic [c_FW-1:0] r_cnt;
      // A line only changes after FILTER_LEN consecutive disagreeing samples.
      always_ff @(posedge clk25 or negedge rst_n) begin
        if (!rst_n) begin
          r_level <= 1'b1;
          r_cnt   <= '0;
        end else if (r_sync2[g] == r_level) begin
          r_cnt <= '0;
        end else if (r_cnt == c_FW'(FILTER_LEN - 1)) begin
          r_level <= r_sync2[g];
          r_cnt   <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
      assign w_filt[g] = r_level;
    end
  endgenerate

  // Falling edge of the filtered PS/2 clock.
  always_ff @(posedge clk25 or negedge rst_n) begin
    if (!rst_n) r_clk_prev <= 1'b1;
    else        r_clk_prev <= w_filt[0];
  end
  assign w_fall = r_clk_prev & ~w_filt[0];

  // Bits enter at the top, so after ten shifts bit 0 holds the start bit.
  assign w_frame    = {w_filt[1], r_shreg};
  assign w_frame_ok = ~w_frame[0] & (^w_frame[9:1]) & w_frame[10];

`ifdef PS2_TIMEOUT_EN
  logic [c_TO_W-1:0] r_to_cnt;
`else
  logic w_unused_cfg;
  assign w_unused_cfg = (c_TO_W > 0);
`endif

  // Frame receiver: collect 11 bits, hand good bytes on, flag bad frames.
  always_ff @(posedge clk25 or negedge rst_n) begin
    if (!rst_n) begin
      r_bit_cnt  <= 4'd0;
      r_shreg    <= 10'd0;
      r_byte     <= 8'h00;
      r_byte_vld <= 1'b0;
      r_ferr     <= 1'b0;
`ifdef PS2_TIMEOUT_EN
      r_to_cnt   <= '0;
`endif
    end else begin
      r_byte_vld <= 1'b0;
      r_ferr     <= 1'b0;
      if (w_fall) begin
        if (r_bit_cnt == 4'd10) begin
          r_bit_cnt <= 4'd0;
          if (w_frame_ok) begin
            r_byte     <= w_frame[8:1];
            r_byte_vld <= 1'b1;
          end else begin
            r_ferr <= 1'b1;
          end
        end else begin
          r_bit_cnt <= r_bit_cnt + 4'd1;
          r_shreg   <= w_frame[10:1];
        end
      end
`ifdef PS2_TIMEOUT_EN
      // Idle watchdog: a partial frame is abandoned; decoder state is kept.
      if (w_fall || r_bit_cnt == 4'd0) begin
        r_to_cnt <= '0;
      end else if (r_to_cnt == c_TO_W'(c_TIMEOUT_CYC - 1)) begin
        r_to_cnt  <= '0;
        r_bit_cnt <= 4'd0;
        r_ferr    <= 1'b1;
      end else begin
        r_to_cnt <= r_to_cnt + 1'b1;
      end
`endif
    end
  end

  assign w_is_shift = (r_byte == 8'h12) || (r_byte == 8'h59);
  assign w_map      = f_map(r_byte, r_shift);
  assign w_latch    = r_byte_vld & (r_state == ST_IDLE) & w_map[8];
  assign w_rd       = cs & enable;
  assign w_rd_kbd   = w_rd & (address == 2'd0);

  // Prefix decoder, key latch and CPU read port share one register block.
  always_ff @(posedge clk25 or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_shift   <= 1'b0;
      r_key     <= 8'h00;
      r_ready   <= 1'b0;
      r_overrun <= 1'b0;
      r_strobe  <= 1'b0;
      r_dout    <= 8'h00;
    end else begin
      r_strobe <= w_latch;
      if (r_byte_vld) begin
        case (r_state)
          ST_IDLE: begin
            if (r_byte == 8'hF0)      r_state <= ST_BREAK;
            else if (r_byte == 8'hE0) r_state <= ST_EXT;
            else if (w_is_shift)      r_shift <= 1'b1;
          end
          ST_BREAK: begin
            if (w_is_shift) r_shift <= 1'b0;
            r_state <= ST_IDLE;
          end
          ST_EXT:  r_state <= (r_byte == 8'hF0) ? ST_EXT_BREAK : ST_IDLE;
          default: r_state <= ST_IDLE;
        endcase
      end
      // A concurrent KBD read consumes the old key, so overrun is not kept.
      if (w_latch) begin
        r_key     <= w_map[7:0];
        r_ready   <= 1'b1;
        r_overrun <= r_ready & ~w_rd_kbd;
      end else if (w_rd_kbd) begin
        r_ready   <= 1'b0;
        r_overrun <= 1'b0;
      end
      if (w_rd) begin
        case (address)
          2'd0:    r_dout <= r_key;
          2'd1:    r_dout <= {r_ready, r_overrun, 6'b000000};
          default: r_dout <= 8'h00;
        endcase
      end
    end
  end

  assign dout       = r_dout;
  assign key_strobe = r_strobe;
  assign frame_err  = r_ferr;

endmodule

`default_nettype wire

// File: tb/tb_ps2_keyboard.sv
// ============================================================================
// Module   : tb_ps2_keyboard
// Brief    : Self-checking bench for ps2_keyboard: directed scenarios plus a
//            randomised scancode stream compared with a table-driven model.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_ps2_keyboard;

  localparam int HALF = 40;   // PS/2 half period in clk25 cycles

  logic       clk25 = 1'b0;
  logic       rst_n = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_din = 1'b1;
  logic       cs = 1'b0;
  logic       enable = 1'b0;
  logic [1:0] address = 2'd0;
  logic [7:0] dout;
  logic       key_strobe, frame_err;

  int n_assert = 0, n_fail = 0;
  int cyc = 0, t_fall = 0, t_strobe = 0, n_strobe = 0, n_ferr = 0;

  // reference tables
  logic [7:0] sc_let [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
                              8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
                              8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
  logic [7:0] sc_dig [10] = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46, 8'h45};
  logic [7:0] sc_pun [7]  = '{8'h41, 8'h49, 8'h4A, 8'h4C, 8'h52, 8'h4E, 8'h55};
  string s_dig = "1234567890";
  string s_dsh = "!@#$%^&*()";
  string s_pun = ",./;'-=";
  string s_psh = "<>?:\"_+";

  logic       m_shift = 1'b0, m_f0 = 1'b0, m_e0 = 1'b0, m_ready = 1'b0;
  logic [7:0] m_key = 8'h00;

  ps2_keyboard dut (
    .clk25      (clk25),
    .rst_n      (rst_n),
    .ps2_clk    (ps2_clk),
    .ps2_din    (ps2_din),
    .cs         (cs),
    .enable     (enable),
    .address    (address),
    .dout       (dout),
    .key_strobe (key_strobe),
    .frame_err  (frame_err)
  );

  always #20 clk25 = ~clk25;

  always @(posedge clk25) cyc <= cyc + 1;

  always @(negedge clk25) begin
    if (key_strobe) begin
      n_strobe = n_strobe + 1;
      t_strobe = cyc;
    end
    if (frame_err) n_ferr = n_ferr + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [8:0] ref_map(input logic [7:0] b, input logic sh);
    for (int i = 0; i < 26; i++) if (b == sc_let[i]) return {1'b1, 8'h41 + 8'(i) | 8'h80};
    for (int i = 0; i < 10; i++) if (b == sc_dig[i]) return {1'b1, 8'h80 | (sh ? s_dsh[i] : s_dig[i])};
    for (int i = 0; i < 7; i++)  if (b == sc_pun[i]) return {1'b1, 8'h80 | (sh ? s_psh[i] : s_pun[i])};
    case (b)
      8'h29: return {1'b1, 8'h80 | 8'h20};
      8'h5A: return {1'b1, 8'h80 | 8'h0D};
      8'h66: return {1'b1, 8'h80 | 8'h5F};
      8'h76: return {1'b1, 8'h80 | 8'h1B};
      default: return 9'h000;
    endcase
  endfunction

  // Keyboard behaviour: prefix bytes swallow what follows, shift is sticky.
  task automatic model(input logic [7:0] b, output int nk);
    logic [8:0] m;
    nk = 0;
    if (m_e0) begin
      if (m_f0) begin m_e0 = 1'b0; m_f0 = 1'b0; end
      else if (b == 8'hF0) m_f0 = 1'b1;
      else m_e0 = 1'b0;
    end else if (m_f0) begin
      if (b == 8'h12 || b == 8'h59) m_shift = 1'b0;
      m_f0 = 1'b0;
    end else if (b == 8'hF0) m_f0 = 1'b1;
    else if (b == 8'hE0) m_e0 = 1'b1;
    else if (b == 8'h12 || b == 8'h59) m_shift = 1'b1;
    else begin
      m = ref_map(b, m_shift);
      if (m[8]) begin
        m_key = m[7:0];
        m_ready = 1'b1;
        nk = 1;
      end
    end
  endtask

  // Sends the first nbits of a frame; rd_off>0 issues a KBD read rd_off-1
  // cycles after the stop-bit falling edge.
  task automatic send_frame(input logic [7:0] d, input logic bad_par, input int nbits,
                            input int rd_off, output logic [7:0] rd_val);
    logic [10:0] bits;
    bits   = {1'b1, (~^d) ^ bad_par, d, 1'b0};
    rd_val = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      ps2_din = bits[i];
      repeat (HALF) @(negedge clk25);
      ps2_clk = 1'b0;
      t_fall  = cyc;
      for (int k = 0; k < HALF; k++) begin
        if (i == 10 && rd_off > 0 && k == rd_off - 1) begin
          cs = 1'b1; enable = 1'b1; address = 2'd0;
          @(posedge clk25);
          #1 rd_val = dout;
        end
        @(negedge clk25);
        cs = 1'b0; enable = 1'b0;
      end
      ps2_clk = 1'b1;
    end
    repeat (HALF) @(negedge clk25);
  endtask

  task automatic frame(input logic [7:0] d);
    logic [7:0] dummy;
    send_frame(d, 1'b0, 11, 0, dummy);
  endtask

  task automatic rd(input logic [1:0] a, output logic [7:0] v);
    @(negedge clk25);
    cs = 1'b1; enable = 1'b1; address = a;
    @(posedge clk25);
    #1 v = dout;
    @(negedge clk25);
    cs = 1'b0; enable = 1'b0;
  endtask

  initial begin
    logic [7:0] v;
    logic [7:0] pool [$];
    int s0, f0, lat, nk;

    // reset state
    repeat (5) @(negedge clk25);
    #1;
    check("rst_dout", dout, 8'h00);
    check("rst_strobe", key_strobe, 1'b0);
    check("rst_ferr", frame_err, 1'b0);
    @(negedge clk25) rst_n = 1'b1;
    repeat (5) @(negedge clk25);
    rd(2'd1, v); check("rst_kbdcr", v, 8'h00);

    // single key A
    s0 = n_strobe;
    frame(8'h1C);
    check("A_strobe", n_strobe - s0, 1);
    lat = t_strobe - t_fall;
    rd(2'd1, v); check("A_kbdcr", v, 8'h80);
    rd(2'd0, v); check("A_kbd", v, 8'hC1);
    @(negedge clk25); cs = 1'b1; enable = 1'b0; address = 2'd1;
    @(negedge clk25); cs = 1'b0; enable = 1'b1;
    @(negedge clk25); enable = 1'b0;
    check("hold_dout", dout, 8'hC1);
    rd(2'd3, v); check("addr3", v, 8'h00);
    rd(2'd1, v); check("A_kbdcr_clr", v, 8'h00);

    // make/break produces one key
    s0 = n_strobe;
    frame(8'h1C); frame(8'hF0); frame(8'h1C);
    check("brk_strobe", n_strobe - s0, 1);
    rd(2'd0, v); check("brk_kbd", v, 8'hC1);

    // shift handling
    s0 = n_strobe;
    frame(8'h12); frame(8'h16);
    rd(2'd0, v); check("shift1_kbd", v, 8'hA1);
    frame(8'hF0); frame(8'h12); frame(8'h16);
    rd(2'd0, v); check("unshift1_kbd", v, 8'hB1);
    check("shift_strobes", n_strobe - s0, 2);

    // bad parity
    s0 = n_strobe; f0 = n_ferr;
    send_frame(8'h1C, 1'b1, 11, 0, v);
    check("par_ferr", n_ferr - f0, 1);
    check("par_strobe", n_strobe - s0, 0);
    rd(2'd1, v); check("par_kbdcr", v, 8'h00);
    frame(8'h32);
    rd(2'd0, v); check("B_kbd", v, 8'hC2);

    // overrun
    frame(8'h1C); frame(8'h32);
    rd(2'd1, v); check("ovr_kbdcr", v, 8'hC0);
    rd(2'd0, v); check("ovr_kbd", v, 8'hC2);
    rd(2'd1, v); check("ovr_kbdcr_clr", v, 8'h00);

    // KBD read coinciding with a latch
    frame(8'h1C); frame(8'h32);
    send_frame(8'h21, 1'b0, 11, lat, v);
    check("sim_old_key", v, 8'hC2);
    rd(2'd1, v); check("sim_kbdcr", v, 8'h80);
    rd(2'd0, v); check("sim_kbd", v, 8'hC3);

    // reset mid-frame
    send_frame(8'h5A, 1'b0, 5, 0, v);
    @(negedge clk25) rst_n = 1'b0;
    #1;
    check("mid_rst_dout", dout, 8'h00);
    check("mid_rst_strobe", key_strobe, 1'b0);
    check("mid_rst_ferr", frame_err, 1'b0);
    ps2_din = 1'b1;
    repeat (3) @(negedge clk25);
    rst_n = 1'b1;
    repeat (5) @(negedge clk25);
    rd(2'd1, v); check("mid_rst_kbdcr", v, 8'h00);
    frame(8'h5A);
    rd(2'd0, v); check("enter_kbd", v, 8'h8D);

`ifdef PS2_TIMEOUT_EN
    f0 = n_ferr;
    send_frame(8'h29, 1'b0, 4, 0, v);
    repeat (6500) @(negedge clk25);
    check("timeout_ferr", n_ferr - f0, 1);
    frame(8'h29);
    rd(2'd0, v); check("timeout_next", v, 8'hA0);
`endif

    // randomised stream against the model
    foreach (sc_let[i]) pool.push_back(sc_let[i]);
    foreach (sc_dig[i]) pool.push_back(sc_dig[i]);
    foreach (sc_pun[i]) pool.push_back(sc_pun[i]);
    pool.push_back(8'h29); pool.push_back(8'h5A); pool.push_back(8'h66); pool.push_back(8'h76);
    pool.push_back(8'h12); pool.push_back(8'h59); pool.push_back(8'h12);
    pool.push_back(8'hF0); pool.push_back(8'hF0); pool.push_back(8'hE0);
    pool.push_back(8'h05); pool.push_back(8'h0D); pool.push_back(8'h14);
    for (int it = 0; it < 40; it++) begin
      logic [7:0] b;
      b  = pool[$urandom_range(0, pool.size() - 1)];
      s0 = n_strobe;
      frame(b);
      model(b, nk);
      check("rnd_strobe", n_strobe - s0, nk);
      rd(2'd1, v); check("rnd_kbdcr", v, {m_ready, 7'b0000000});
      if (m_ready) begin
        rd(2'd0, v); check("rnd_kbd", v, m_key);
        m_ready = 1'b0;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
